// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared definitions for the counter command sequencer.
// Holds the opcode encodings, the sequencer FSM states and the command
// record layout used between the top level and its command FIFO.
package counter_cmd_sequencer_pkg;

    // Command opcodes as presented on CmdOp_i.
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_e;

    // Sequencer FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Width of the opcode field in a command record.
    localparam int unsigned OP_W = 2;

    // A command record is packed MSB->LSB as {op, data, repeat}.
    function automatic int unsigned cmd_width(input int unsigned data_w,
                                              input int unsigned rep_w);
        return OP_W + data_w + rep_w;
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO for the counter command sequencer.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset, empties the FIFO
//   push_i   - write data_i (ignored while full)
//   data_i   - entry to write
//   pop_i    - drop the head entry (ignored while empty)
//   data_o   - head entry (valid while not empty)
//   full_o   - all DEPTH entries occupied
//   empty_o  - no entries occupied
module cmd_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Counter command sequencer: accepts counter commands over a valid/ready
// port, queues them, and replays each one cycle-accurately onto the
// In/Up/Down/Load controls of a synchronous counter. Rising edges of the
// counter's carry output are counted in a saturating counter.
// Ports:
//   Clock_i       - clock, rising edge
//   Reset_i       - synchronous active-high reset
//   CmdValid_i    - command offered
//   CmdReady_o    - FIFO not full
//   CmdOp_i       - opcode (NOP/LOAD/UP/DOWN)
//   CmdData_i     - LOAD value
//   CmdRepeat_i   - extra cycles; command lasts CmdRepeat+1 cycles
//   In_o, Up_o, Down_o, Load_o - registered counter controls
//   Cout_i        - carry/borrow from the counter
//   Busy_o        - issuing or commands queued
//   Done_o        - pulse after the final control cycle when queue is empty
//   CarryCount_o  - saturating count of Cout rising edges
module counter_cmd_sequencer
    import counter_cmd_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned REP_W = 4,
    parameter int unsigned CC_W  = 8
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             CmdValid_i,
    output logic             CmdReady_o,
    input  logic [1:0]       CmdOp_i,
    input  logic [WIDTH-1:0] CmdData_i,
    input  logic [REP_W-1:0] CmdRepeat_i,
    output logic [WIDTH-1:0] In_o,
    output logic             Up_o,
    output logic             Down_o,
    output logic             Load_o,
    input  logic             Cout_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [CC_W-1:0]  CarryCount_o
);

    localparam int unsigned CMD_W = cmd_width(WIDTH, REP_W);

    // FIFO interface
    logic [CMD_W-1:0] push_word;
    logic [CMD_W-1:0] head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    op_e              head_op;
    logic [WIDTH-1:0] head_data;
    logic [REP_W-1:0] head_rep;

    // Sequencer state
    state_e           state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             load_q, load_d;
    logic             done_q, done_d;
    logic             start;

    // Carry counting
    logic             cout_q;
    logic [CC_W-1:0]  cc_q;

    assign push_word = {CmdOp_i, CmdData_i, CmdRepeat_i};
    assign head_op   = op_e'(head_word[CMD_W-1 -: OP_W]);
    assign head_data = head_word[REP_W +: WIDTH];
    assign head_rep  = head_word[REP_W-1:0];

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i   (Clock_i),
        .rst_i   (Reset_i),
        .push_i  (CmdValid_i),
        .data_i  (push_word),
        .pop_i   (pop),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            in_q    <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            in_q    <= in_d;
            up_q    <= up_d;
            down_q  <= down_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    // Both IDLE and a finished ISSUE can start the next command; the shared
    // start path below keeps back-to-back commands free of bubbles.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        in_d    = in_q;
        up_d    = up_q;
        down_d  = down_q;
        load_d  = load_q;
        done_d  = 1'b0;
        start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                up_d   = 1'b0;
                down_d = 1'b0;
                load_d = 1'b0;
                start  = !fifo_empty;
            end
            ST_ISSUE: begin
                if (rep_q != '0) begin
                    rep_d = rep_q - REP_W'(1);
                end else if (!fifo_empty) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    up_d    = 1'b0;
                    down_d  = 1'b0;
                    load_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d = ST_ISSUE;
            rep_d   = head_rep;
            up_d    = (head_op == OP_UP);
            down_d  = (head_op == OP_DOWN);
            load_d  = (head_op == OP_LOAD);
            if (head_op == OP_LOAD) begin
                in_d = head_data;
            end
        end
    end

    assign pop = start;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            cout_q <= 1'b0;
            cc_q   <= '0;
        end else begin
            cout_q <= Cout_i;
            if (Cout_i && !cout_q && (cc_q != '1)) begin
                cc_q <= cc_q + CC_W'(1);
            end
        end
    end

    assign CmdReady_o   = !fifo_full;
    assign In_o         = in_q;
    assign Up_o         = up_q;
    assign Down_o       = down_q;
    assign Load_o       = load_q;
    assign Done_o       = done_q;
    assign Busy_o       = (state_q == ST_ISSUE) || !fifo_empty;
    assign CarryCount_o = cc_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed self-checking bench for counter_cmd_sequencer driving a
// behavioural 4-bit synchronous counter as its load.
module tb_counter_cmd_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned REP_W = 4;
    localparam int unsigned CC_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [REP_W-1:0] cmd_rep = '0;
    logic [WIDTH-1:0] in_o;
    logic             up_o, down_o, load_o;
    logic             cout;
    logic             busy, done;
    logic [CC_W-1:0]  carry_cnt;

    // Behavioural counter load and Cout override
    logic [WIDTH-1:0] ctr = '0;
    logic             ctr_cout;
    logic             cout_force = 1'b0;
    logic             cout_drv = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_o)      ctr <= in_o;
        else if (up_o)   ctr <= ctr + 4'd1;
        else if (down_o) ctr <= ctr - 4'd1;
    end

    assign ctr_cout = (up_o && ctr == 4'hF) || (down_o && ctr == 4'h0);
    assign cout     = cout_force ? cout_drv : ctr_cout;

    counter_cmd_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .REP_W (REP_W),
        .CC_W  (CC_W)
    ) dut (
        .Clock_i      (clk),
        .Reset_i      (rst),
        .CmdValid_i   (cmd_valid),
        .CmdReady_o   (cmd_ready),
        .CmdOp_i      (cmd_op),
        .CmdData_i    (cmd_data),
        .CmdRepeat_i  (cmd_rep),
        .In_o         (in_o),
        .Up_o         (up_o),
        .Down_o       (down_o),
        .Load_o       (load_o),
        .Cout_i       (cout),
        .Busy_o       (busy),
        .Done_o       (done),
        .CarryCount_o (carry_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [3:0] data, input logic [3:0] rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_rep   = rep;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({up_o, down_o, load_o, done, busy} !== 5'b0 || in_o !== 4'h0 || carry_cnt !== 8'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: up=%b down=%b load=%b done=%b busy=%b in=%h cc=%0d ready=%b, required all 0 and ready=1",
                     up_o, down_o, load_o, done, busy, in_o, carry_cnt, cmd_ready);
        end
    endtask

    // LOAD 0xA repeat 0 pushed in cycle t: Load only in t+2, Done in t+3.
    task automatic test_load_latency();
        do_reset();
        offer(2'd1, 4'hA, 4'd0);
        step();
        cmd_valid = 1'b0;
        checks++;
        if (load_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_t1: load=%b busy=%b, required load=0 busy=1", load_o, busy);
        end
        step();
        checks++;
        if (load_o !== 1'b1 || in_o !== 4'hA || done !== 1'b0 || up_o !== 1'b0 || down_o !== 1'b0) begin
            errors++;
            $display("FAIL load_t2: load=%b in=%h done=%b, required load=1 in=a done=0", load_o, in_o, done);
        end
        step();
        checks++;
        if (load_o !== 1'b0 || done !== 1'b1 || ctr !== 4'hA || in_o !== 4'hA) begin
            errors++;
            $display("FAIL load_t3: load=%b done=%b out=%h in=%h, required load=0 done=1 out=a in=a", load_o, done, ctr, in_o);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_t4: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    // LOAD 0xA then UP x6 back-to-back; counter wraps once.
    task automatic test_back_to_back();
        logic [3:0] exp_ctr;
        do_reset();
        offer(2'd1, 4'hA, 4'd0);
        step();
        offer(2'd2, 4'h0, 4'd5);
        step();
        cmd_valid = 1'b0;
        checks++;
        if (load_o !== 1'b1 || in_o !== 4'hA) begin
            errors++;
            $display("FAIL b2b_load: load=%b in=%h, required 1 a", load_o, in_o);
        end
        exp_ctr = 4'hA;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (up_o !== 1'b1 || load_o !== 1'b0 || down_o !== 1'b0 || done !== 1'b0 || ctr !== exp_ctr) begin
                errors++;
                $display("FAIL b2b_up[%0d]: up=%b load=%b down=%b done=%b out=%h, required up=1 out=%h",
                         i, up_o, load_o, down_o, done, ctr, exp_ctr);
            end
            exp_ctr = exp_ctr + 4'd1;
        end
        step();
        checks++;
        if (up_o !== 1'b0 || done !== 1'b1 || ctr !== 4'h0 || carry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL b2b_end: up=%b done=%b out=%h cc=%0d, required up=0 done=1 out=0 cc=1", up_o, done, ctr, carry_cnt);
        end
    endtask

    // LOAD 1 then DOWN repeat 2: Out 0, F, E with one borrow counted.
    task automatic test_down_borrow();
        logic [7:0] cc0;
        logic [3:0] exp_vals [3];
        exp_vals[0] = 4'h1;
        exp_vals[1] = 4'h0;
        exp_vals[2] = 4'hF;
        cc0 = carry_cnt;
        offer(2'd1, 4'h1, 4'd0);
        step();
        offer(2'd3, 4'h0, 4'd2);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (down_o !== 1'b1 || up_o !== 1'b0 || load_o !== 1'b0 || ctr !== exp_vals[i]) begin
                errors++;
                $display("FAIL down[%0d]: down=%b up=%b load=%b out=%h, required down=1 out=%h",
                         i, down_o, up_o, load_o, ctr, exp_vals[i]);
            end
        end
        step();
        checks++;
        if (down_o !== 1'b0 || done !== 1'b1 || ctr !== 4'hE || carry_cnt !== cc0 + 8'd1) begin
            errors++;
            $display("FAIL down_end: down=%b done=%b out=%h cc=%0d, required down=0 done=1 out=e cc=%0d",
                     down_o, done, ctr, carry_cnt, cc0 + 8'd1);
        end
    endtask

    // Fill the FIFO behind a 16-cycle NOP; the 5th push waits for a pop.
    task automatic test_fifo_full();
        int n;
        logic [2:0] exp_ctl [4];
        logic [3:0] exp_out [4];
        exp_ctl[0] = 3'b100; exp_out[0] = 4'h3;
        exp_ctl[1] = 3'b100; exp_out[1] = 4'h4;
        exp_ctl[2] = 3'b010; exp_out[2] = 4'h5;
        exp_ctl[3] = 3'b001; exp_out[3] = 4'h4;
        do_reset();
        offer(2'd0, 4'h0, 4'd15);
        step();
        cmd_valid = 1'b0;
        step();
        offer(2'd1, 4'h3, 4'd0); step();
        offer(2'd2, 4'h0, 4'd0); step();
        offer(2'd2, 4'h0, 4'd0); step();
        offer(2'd3, 4'h0, 4'd0); step();
        offer(2'd1, 4'h7, 4'd0);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: ready=%b busy=%b, required ready=0 busy=1", cmd_ready, busy);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 30) begin
            checks++;
            if (up_o | down_o | load_o) begin
                errors++;
                $display("FAIL nop_controls[%0d]: up=%b down=%b load=%b, required all 0", n, up_o, down_o, load_o);
            end
            step();
            n++;
        end
        checks++;
        if (n !== 12 || load_o !== 1'b1 || in_o !== 4'h3) begin
            errors++;
            $display("FAIL full_release: held=%0d load=%b in=%h, required held=12 load=1 in=3", n, load_o, in_o);
        end
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({up_o, down_o, load_o} !== exp_ctl[i] || ctr !== exp_out[i]) begin
                errors++;
                $display("FAIL order[%0d]: ctl=%b out=%h, required ctl=%b out=%h", i, {up_o, down_o, load_o}, ctr, exp_ctl[i], exp_out[i]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || ctr !== 4'h7 || in_o !== 4'h7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end: done=%b out=%h in=%h busy=%b, required done=1 out=7 in=7 busy=0", done, ctr, in_o, busy);
        end
    endtask

    // Reset in the 3rd UP cycle with two commands queued.
    task automatic test_reset_mid();
        int bad;
        do_reset();
        cout_force = 1'b1;
        cout_drv = 1'b1;
        step();
        cout_drv = 1'b0;
        step();
        cout_force = 1'b0;
        checks++;
        if (carry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_precount: cc=%0d, required 1", carry_cnt);
        end
        offer(2'd2, 4'h0, 4'd7); step();
        offer(2'd3, 4'h0, 4'd0); step();
        offer(2'd1, 4'h5, 4'd0); step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (up_o !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_up3: up=%b busy=%b, required 1 1", up_o, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (up_o !== 1'b0 || busy !== 1'b0 || carry_cnt !== 8'd0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: up=%b busy=%b cc=%0d ready=%b done=%b, required 0 0 0 1 0",
                     up_o, busy, carry_cnt, cmd_ready, done);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (up_o | down_o | load_o | busy | done) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_dropped: active cycles=%0d, required 0", bad);
        end
    endtask

    // Level-held Cout counts once; 300 edges saturate at 255.
    task automatic test_saturate();
        do_reset();
        cout_force = 1'b1;
        cout_drv = 1'b1;
        step(); step(); step();
        cout_drv = 1'b0;
        step();
        checks++;
        if (carry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL cout_level: cc=%0d, required 1", carry_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            cout_drv = 1'b1;
            step();
            cout_drv = 1'b0;
            step();
            if (i == 8) begin
                checks++;
                if (carry_cnt !== 8'd10) begin
                    errors++;
                    $display("FAIL cc_10: cc=%0d, required 10", carry_cnt);
                end
            end
            if (i == 252) begin
                checks++;
                if (carry_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL cc_254: cc=%0d, required 254", carry_cnt);
                end
            end
            if (i == 253) begin
                checks++;
                if (carry_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL cc_255: cc=%0d, required 255", carry_cnt);
                end
            end
        end
        checks++;
        if (carry_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cc_sat: cc=%0d, required 255", carry_cnt);
        end
        cout_force = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_back_to_back();
        test_down_borrow();
        test_fifo_full();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
